// File: rtl/calc_result_tx.sv
// Bit-serial transmitter for the calculator result word: start bit, DATA_W data bits LSB-first,
// optional even parity bit (CALC_TX_PARITY_EN), STOP_BITS stop bits; the serial line idles high.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line high, tx_ready high once out of reset, waiting for accept
// S_START  | start bit (low) for CLKS_PER_BIT cycles
// S_DATA   | data bits LSB first, CLKS_PER_BIT cycles each
// S_PARITY | even parity bit (CALC_TX_PARITY_EN builds only)
// S_STOP   | STOP_BITS high bits; last cycle returns to S_IDLE with tx_done
module calc_result_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic              clck,
   input  logic              reste,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_MAX = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] STOP_MAX = BIT_W'(STOP_BITS - 1);

`ifdef CALC_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              out_q, out_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              baud_end;
`ifdef CALC_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   always_ff @(posedge clck or negedge reste) begin
      if (!reste) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         out_q   <= 1'b1;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef CALC_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         out_q   <= out_d;
         ready_q <= ready_d;
         done_q  <= done_d;
`ifdef CALC_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign baud_end = (cnt_q == CNT_MAX);

   // out_d is the line level for the bit of the current state; registering it
   // puts the start bit on the line one edge after the accept edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      out_d   = 1'b1;
`ifdef CALC_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
            if (ready_q && tx_valid) begin
               sh_d    = tx_data;
               ready_d = 1'b0;
               state_d = S_START;
`ifdef CALC_TX_PARITY_EN
               par_d   = ^tx_data;
`endif
            end
         end
         S_START: begin
            out_d = 1'b0;
            if (baud_end) begin
               cnt_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            out_d = sh_q[0];
            if (baud_end) begin
               cnt_d = '0;
               sh_d  = sh_q >> 1;
               if (bit_q == DATA_MAX) begin
                  bit_d = '0;
`ifdef CALC_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef CALC_TX_PARITY_EN
         S_PARITY: begin
            out_d = par_q;
            if (baud_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            out_d = 1'b1;
            if (baud_end) begin
               cnt_d = '0;
               if (bit_q == STOP_MAX) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign tx_ready = ready_q;
   assign tx_out   = out_q;
   assign tx_busy  = (state_q != S_IDLE);
   assign tx_done  = done_q;

endmodule
